// File: rtl/dlfp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dlfp_pkg
// Brief    : Shared unit codes, default FU count, canonical quiet NaN and the
//            issue-controller state encoding for the DLFloat16 FPU slice.
// Revision : 1.0  initial release
// ============================================================================
package dlfp_pkg;

    // Functional-unit select codes carried on the decoder's ena field
    localparam logic [3:0] ENA_ADD     = 4'd1;
    localparam logic [3:0] ENA_MUL     = 4'd2;
    localparam logic [3:0] ENA_DIV     = 4'd3;
    localparam logic [3:0] ENA_SQRT    = 4'd4;
    localparam logic [3:0] ENA_SGNJ    = 4'd5;
    localparam logic [3:0] ENA_CMP     = 4'd6;
    localparam logic [3:0] ENA_CVT_I2F = 4'd7;
    localparam logic [3:0] ENA_CVT_F2I = 4'd8;
    localparam logic [3:0] ENA_FMA     = 4'd9;

    localparam int NUM_FU_DEF = 9;

    // Result returned for illegal ops and watchdog-forced completions
    localparam logic [15:0] DLF_QNAN = 16'h7FFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } issue_state_e;

endpackage : dlfp_pkg
`default_nettype wire

// File: rtl/dlfp_wdog.sv
`default_nettype none
// ============================================================================
// Module   : dlfp_wdog
// Brief    : Wait-state watchdog. Counts cycles while run is high, clears
//            whenever run is low, and flags the last permitted cycle so the
//            controller leaves WAIT after exactly TIMEOUT cycles.
// Revision : 1.0  initial release
// ============================================================================
module dlfp_wdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    // Cycle counter: zero outside WAIT, saturates at the final count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!run) begin
            r_cnt <= '0;
        end else if (r_cnt != CW'(TIMEOUT - 1)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = run && (r_cnt == CW'(TIMEOUT - 1));

endmodule : dlfp_wdog
`default_nettype wire

// File: rtl/dlfp_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dlfp_issue_ctrl
// Brief    : Single-op issue stage behind the DLFloat16 decoder. Launches one
//            op on one functional unit, waits for its done strobe and returns
//            the result on a valid/ready writeback port.
//            Optional watchdog: define DLFP_ISSUE_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module dlfp_issue_ctrl
    import dlfp_pkg::*;
#(
    parameter int DW      = 16,
    parameter int NUM_FU  = NUM_FU_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_ena,
    input  logic                 in_op,
    input  logic [1:0]           in_sel1,
    input  logic [2:0]           in_sel2,
    input  logic [2:0]           in_rm,
    input  logic [DW-1:0]        in_rs1,
    input  logic [DW-1:0]        in_rs2,
    input  logic [DW-1:0]        in_rs3,
    input  logic [4:0]           in_rd,
    output logic [NUM_FU-1:0]    fu_start,
    output logic                 fu_op,
    output logic [1:0]           fu_sel1,
    output logic [2:0]           fu_sel2,
    output logic [2:0]           fu_rm,
    output logic [DW-1:0]        fu_a,
    output logic [DW-1:0]        fu_b,
    output logic [DW-1:0]        fu_c,
    input  logic [NUM_FU-1:0]    fu_done,
    input  logic [NUM_FU*DW-1:0] fu_result,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [DW-1:0]        wb_data,
    output logic [4:0]           wb_rd,
    output logic                 wb_illegal,
    output logic                 wb_timeout,
    output logic [15:0]          op_count
);

    issue_state_e r_state;
    issue_state_e w_state_nxt;

    logic [3:0]        r_ena;
    logic              r_op;
    logic [1:0]        r_sel1;
    logic [2:0]        r_sel2;
    logic [2:0]        r_rm;
    logic [DW-1:0]     r_a;
    logic [DW-1:0]     r_b;
    logic [DW-1:0]     r_c;
    logic [4:0]        r_rd;
    logic [DW-1:0]     r_wb_data;
    logic              r_wb_illegal;
    logic              r_wb_timeout;
    logic [15:0]       r_op_count;

    logic [NUM_FU-1:0] w_sel;
    logic [DW-1:0]     w_res;
    logic              w_done;
    logic              w_in_legal;
    logic              w_accept;
    logic              w_expired;

    assign w_in_legal = (int'(in_ena) >= 1) && (int'(in_ena) <= NUM_FU);
    assign w_accept   = in_valid && in_ready;

    // One-hot decode of the latched unit select (index = ena - 1)
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_sel
        assign w_sel[gi] = (int'(r_ena) == gi + 1);
    end

    // Only the selected unit's done counts; stray strobes from others are masked
    assign w_done = |(fu_done & w_sel);

    // Result slice of the selected unit
    always_comb begin
        w_res = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_sel[i]) begin
                w_res = w_res | fu_result[i*DW +: DW];
            end
        end
    end

`ifdef DLFP_ISSUE_TIMEOUT_EN
    dlfp_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (r_state == ST_WAIT),
        .expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; done takes priority over a simultaneous expiry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_in_legal ? ST_ISSUE : ST_WB;
            ST_ISSUE: w_state_nxt = w_done ? ST_WB : ST_WAIT;
            ST_WAIT:  if (w_done || w_expired) w_state_nxt = ST_WB;
            ST_WB:    if (wb_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Op latch, result capture and completed-op counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ena        <= '0;
            r_op         <= 1'b0;
            r_sel1       <= '0;
            r_sel2       <= '0;
            r_rm         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_c          <= '0;
            r_rd         <= '0;
            r_wb_data    <= '0;
            r_wb_illegal <= 1'b0;
            r_wb_timeout <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_ena        <= in_ena;
                        r_op         <= in_op;
                        r_sel1       <= in_sel1;
                        r_sel2       <= in_sel2;
                        r_rm         <= in_rm;
                        r_a          <= in_rs1;
                        r_b          <= in_rs2;
                        r_c          <= in_rs3;
                        r_rd         <= in_rd;
                        r_wb_illegal <= !w_in_legal;
                        r_wb_timeout <= 1'b0;
                        if (!w_in_legal) begin
                            r_wb_data <= DW'(DLF_QNAN);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_done) begin
                        r_wb_data <= w_res;
                    end
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_wb_data <= w_res;
                    end else if (w_expired) begin
                        r_wb_data    <= DW'(DLF_QNAN);
                        r_wb_timeout <= 1'b1;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        r_op_count <= r_op_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign fu_start   = (r_state == ST_ISSUE) ? w_sel : '0;
    assign fu_op      = r_op;
    assign fu_sel1    = r_sel1;
    assign fu_sel2    = r_sel2;
    assign fu_rm      = r_rm;
    assign fu_a       = r_a;
    assign fu_b       = r_b;
    assign fu_c       = r_c;
    assign wb_valid   = (r_state == ST_WB);
    assign wb_data    = r_wb_data;
    assign wb_rd      = r_rd;
    assign wb_illegal = r_wb_illegal;
    assign wb_timeout = r_wb_timeout;
    assign op_count   = r_op_count;

endmodule : dlfp_issue_ctrl
`default_nettype wire
